// File: rtl/sdram_cmd_pkg.sv
// Shared SDRAM command encodings, error-flag positions and mode-register decode
// used by the responder model and its bench.
package sdram_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  localparam int ERR_IDLE  = 0;
  localparam int ERR_STATE = 1;
  localparam int ERR_BUS   = 2;

  // Only these CAS latencies are accepted; the read pipe relies on CL >= 2.
  localparam logic [2:0] CL_MIN = 3'd2;
  localparam logic [2:0] CL_MAX = 3'd3;

  typedef struct packed {
    logic [3:0] len;
    logic [1:0] lg;
  } burst_t;

  function automatic burst_t bl_decode(input logic [2:0] code);
    burst_t b;
    case (code)
      3'd1:    b = '{len: 4'd2, lg: 2'd1};
      3'd2:    b = '{len: 4'd4, lg: 2'd2};
      3'd3:    b = '{len: 4'd8, lg: 2'd3};
      default: b = '{len: 4'd1, lg: 2'd0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port 16-bit RAM with registered read and independent byte-lane writes.
module sdram_resp_mem #(
  parameter int ABITS = 14
) (
  input  logic             clk,
  input  logic [1:0]       we,
  input  logic [ABITS-1:0] addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);
  localparam int DEPTH = 1 << ABITS;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) lane_mem[addr] <= wdata[gi*8 +: 8];
        lane_q_reg <= lane_mem[addr];
      end

      assign rdata[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

endmodule

// File: rtl/sdram_resp_model.sv
// SDR SDRAM device-side responder: command decode, bank/mode state, write bursts
// and a CAS-latency read pipe in front of a small banked memory.
module sdram_resp_model
  import sdram_cmd_pkg::*;
#(
  parameter int ROW_BITS  = 4,
  parameter int COL_BITS  = 8,
  parameter int MEM_ABITS = 2 + ROW_BITS + COL_BITS
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        SDRAM_CSn,
  input  logic        SDRAM_RASn,
  input  logic        SDRAM_CASn,
  input  logic        SDRAM_WEn,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_ADDR,
  input  logic        SDRAM_LDQM,
  input  logic        SDRAM_UDQM,
  input  logic [15:0] SDRAM_Dout,
  input  logic        SDRAM_DEn,
  output logic [15:0] SDRAM_Din,
  output logic        SDRAM_Doe,
  output logic [2:0]  err
);
  typedef logic [MEM_ABITS-1:0] idx_t;

  cmd_e                cmd;
  logic                bank_open_reg [4];
  logic [ROW_BITS-1:0] bank_row_reg  [4];
  logic                any_open, cmd_bank_open, rd_ok, wr_ok, wr_stop;
  idx_t                cmd_idx;
  burst_t              mode_bl_reg;
  logic [2:0]          cl_reg, mode_mask;

  logic       wr_act_reg, wr_act_next, rd_act_reg, rd_act_next;
  idx_t       wr_base_reg, wr_base_next, rd_base_reg, rd_base_next;
  logic [2:0] wr_k_reg, wr_k_next, rd_k_reg, rd_k_next;
  logic [2:0] wr_left_reg, wr_left_next, rd_left_reg, rd_left_next;
  logic [2:0] wr_mask_reg, wr_mask_next, rd_mask_reg, rd_mask_next;
  logic       dly_valid_reg, dly_valid_next, iss_valid_reg, iss_valid_next;
  idx_t       dly_idx_reg, dly_idx_next;
  logic [1:0] iss_dqm_reg;
  logic       wr_word, gen_valid, issue_valid, doe_reg, doe_next;
  idx_t       wr_idx, gen_idx, issue_idx, ram_addr;
  logic [1:0] ram_we;
  logic [15:0] ram_q, din_reg, din_next;
  logic [2:0] err_reg, err_next;
  logic       unused_addr;

  function automatic idx_t wrap_idx(input idx_t base, input logic [2:0] k, input logic [2:0] mask);
    idx_t m;
    m = idx_t'(mask);
    return (base & ~m) | ((base + idx_t'(k)) & m);
  endfunction

  assign cmd = SDRAM_CSn ? CMD_NOP : cmd_e'({SDRAM_RASn, SDRAM_CASn, SDRAM_WEn});
  assign cmd_bank_open = bank_open_reg[SDRAM_BA];
  assign cmd_idx = {SDRAM_BA, bank_row_reg[SDRAM_BA], SDRAM_ADDR[COL_BITS-1:0]};
  assign rd_ok = (cmd == CMD_RD) && cmd_bank_open;
  assign wr_ok = (cmd == CMD_WR) && cmd_bank_open;
  assign mode_mask = 3'((4'd1 << mode_bl_reg.lg) - 4'd1);
  assign unused_addr = ^SDRAM_ADDR;

  // A write burst ends on READ, BURST TERMINATE or a precharge hitting its bank.
  assign wr_stop = rd_ok || (cmd == CMD_BST) ||
                   ((cmd == CMD_PRE) && (SDRAM_ADDR[10] || (SDRAM_BA == wr_base_reg[MEM_ABITS-1 -: 2])));

  always_comb begin
    any_open = 1'b0;
    for (int b = 0; b < 4; b++) any_open = any_open | bank_open_reg[b];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      always_ff @(posedge m_clock) begin
        if (p_reset) begin
          bank_open_reg[gi] <= 1'b0;
        end else if ((cmd == CMD_ACT) && (SDRAM_BA == 2'(gi)) && !bank_open_reg[gi]) begin
          bank_open_reg[gi] <= 1'b1;
          bank_row_reg[gi]  <= SDRAM_ADDR[ROW_BITS-1:0];
        end else if ((cmd == CMD_PRE) && (SDRAM_ADDR[10] || (SDRAM_BA == 2'(gi)))) begin
          bank_open_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    wr_act_next  = 1'b0;
    wr_base_next = wr_base_reg;
    wr_k_next    = wr_k_reg;
    wr_left_next = wr_left_reg;
    wr_mask_next = wr_mask_reg;
    wr_word      = 1'b0;
    wr_idx       = wrap_idx(wr_base_reg, wr_k_reg, wr_mask_reg);
    if (wr_ok) begin
      wr_word      = 1'b1;
      wr_idx       = cmd_idx;
      wr_act_next  = (mode_bl_reg.len != 4'd1);
      wr_base_next = cmd_idx;
      wr_k_next    = 3'd1;
      wr_left_next = 3'(mode_bl_reg.len - 4'd1);
      wr_mask_next = mode_mask;
    end else if (wr_act_reg && !wr_stop) begin
      wr_word      = 1'b1;
      wr_act_next  = (wr_left_reg != 3'd1);
      wr_k_next    = wr_k_reg + 3'd1;
      wr_left_next = wr_left_reg - 3'd1;
    end

    // Read words are generated at command-edge + k; a BST still lets this edge's word go.
    rd_act_next  = 1'b0;
    rd_base_next = rd_base_reg;
    rd_k_next    = rd_k_reg;
    rd_left_next = rd_left_reg;
    rd_mask_next = rd_mask_reg;
    gen_valid    = 1'b0;
    gen_idx      = wrap_idx(rd_base_reg, rd_k_reg, rd_mask_reg);
    if (rd_ok) begin
      gen_valid    = 1'b1;
      gen_idx      = cmd_idx;
      rd_act_next  = (mode_bl_reg.len != 4'd1);
      rd_base_next = cmd_idx;
      rd_k_next    = 3'd1;
      rd_left_next = 3'(mode_bl_reg.len - 4'd1);
      rd_mask_next = mode_mask;
    end else if (rd_act_reg && !wr_ok) begin
      gen_valid    = 1'b1;
      rd_act_next  = (rd_left_reg != 3'd1) && (cmd != CMD_BST);
      rd_k_next    = rd_k_reg + 3'd1;
      rd_left_next = rd_left_reg - 3'd1;
    end

    // The RAM read is issued CL-2 edges after generation, one edge before driving.
    dly_idx_next = gen_idx;
    if (cl_reg == CL_MAX) begin
      issue_valid    = dly_valid_reg && !wr_ok;
      issue_idx      = dly_idx_reg;
      dly_valid_next = gen_valid;
    end else begin
      issue_valid    = gen_valid;
      issue_idx      = gen_idx;
      dly_valid_next = 1'b0;
    end
    iss_valid_next = issue_valid && !wr_word;
    ram_addr = wr_word ? wr_idx : issue_idx;
    ram_we   = wr_word ? {~SDRAM_UDQM, ~SDRAM_LDQM} : 2'b00;

    doe_next = iss_valid_reg && (iss_dqm_reg != 2'b11);
    din_next = doe_next ? (ram_q & {{8{~iss_dqm_reg[1]}}, {8{~iss_dqm_reg[0]}}}) : 16'h0000;

    err_next = err_reg;
    if (((cmd == CMD_RD) || (cmd == CMD_WR)) && !cmd_bank_open) err_next[ERR_IDLE] = 1'b1;
    if (((cmd == CMD_ACT) && cmd_bank_open) || ((cmd == CMD_REF) && any_open)) err_next[ERR_STATE] = 1'b1;
    if ((wr_word && SDRAM_DEn) || (doe_reg && !SDRAM_DEn)) err_next[ERR_BUS] = 1'b1;
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      mode_bl_reg   <= bl_decode(3'd0);
      cl_reg        <= CL_MIN;
      wr_act_reg    <= 1'b0;
      rd_act_reg    <= 1'b0;
      dly_valid_reg <= 1'b0;
      iss_valid_reg <= 1'b0;
      iss_dqm_reg   <= 2'b00;
      doe_reg       <= 1'b0;
      din_reg       <= 16'h0000;
      err_reg       <= 3'b000;
    end else begin
      if (cmd == CMD_MRS) begin
        mode_bl_reg <= bl_decode(SDRAM_ADDR[2:0]);
        if ((SDRAM_ADDR[6:4] == CL_MIN) || (SDRAM_ADDR[6:4] == CL_MAX)) cl_reg <= SDRAM_ADDR[6:4];
      end
      wr_act_reg    <= wr_act_next;
      rd_act_reg    <= rd_act_next;
      dly_valid_reg <= dly_valid_next;
      iss_valid_reg <= iss_valid_next;
      iss_dqm_reg   <= {SDRAM_UDQM, SDRAM_LDQM};
      doe_reg       <= doe_next;
      din_reg       <= din_next;
      err_reg       <= err_next;
    end
    wr_base_reg <= wr_base_next;
    wr_k_reg    <= wr_k_next;
    wr_left_reg <= wr_left_next;
    wr_mask_reg <= wr_mask_next;
    rd_base_reg <= rd_base_next;
    rd_k_reg    <= rd_k_next;
    rd_left_reg <= rd_left_next;
    rd_mask_reg <= rd_mask_next;
    dly_idx_reg <= dly_idx_next;
  end

  sdram_resp_mem #(.ABITS(MEM_ABITS)) u_mem (
    .clk   (m_clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (SDRAM_Dout),
    .rdata (ram_q)
  );

  assign SDRAM_Din = din_reg;
  assign SDRAM_Doe = doe_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: a vector table for the main read/write
// flows plus hand sequences for burst terminate, errors and reset mid-burst.
module tb_sdram_resp_model;
  import sdram_cmd_pkg::*;

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn;
  logic [1:0]  SDRAM_BA;
  logic [12:0] SDRAM_ADDR;
  logic        SDRAM_LDQM, SDRAM_UDQM;
  logic [15:0] SDRAM_Dout;
  logic        SDRAM_DEn;
  logic [15:0] SDRAM_Din;
  logic        SDRAM_Doe;
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  always #5 m_clock = ~m_clock;

  sdram_resp_model dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .SDRAM_CSn  (SDRAM_CSn),
    .SDRAM_RASn (SDRAM_RASn),
    .SDRAM_CASn (SDRAM_CASn),
    .SDRAM_WEn  (SDRAM_WEn),
    .SDRAM_BA   (SDRAM_BA),
    .SDRAM_ADDR (SDRAM_ADDR),
    .SDRAM_LDQM (SDRAM_LDQM),
    .SDRAM_UDQM (SDRAM_UDQM),
    .SDRAM_Dout (SDRAM_Dout),
    .SDRAM_DEn  (SDRAM_DEn),
    .SDRAM_Din  (SDRAM_Din),
    .SDRAM_Doe  (SDRAM_Doe),
    .err        (err)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dout;
    logic        den;
    logic        doe;
    logic [15:0] din;
    logic [2:0]  err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                              input logic [1:0] dqm, input logic [15:0] dout, input logic den,
                              input logic doe, input logic [15:0] din, input logic [2:0] e);
    vec_t v;
    v.cmd = c; v.ba = ba; v.addr = a; v.dqm = dqm; v.dout = dout; v.den = den;
    v.doe = doe; v.din = din; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one command for one rising edge, then settle just past the edge.
  task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dout, input logic den);
    SDRAM_CSn = (c == CMD_NOP);
    {SDRAM_RASn, SDRAM_CASn, SDRAM_WEn} = c;
    SDRAM_BA = ba;
    SDRAM_ADDR = a;
    {SDRAM_UDQM, SDRAM_LDQM} = dqm;
    SDRAM_Dout = dout;
    SDRAM_DEn = den;
    @(posedge m_clock);
    #1;
  endtask

  task automatic nop(input logic [15:0] dout, input logic den);
    drive(CMD_NOP, 2'd0, 13'h0, 2'b00, dout, den);
  endtask

  task automatic check_bus(input string tag, input logic doe, input logic [15:0] din, input logic [2:0] e);
    check($sformatf("%s doe", tag), 16'(SDRAM_Doe), 16'(doe));
    check($sformatf("%s din", tag), SDRAM_Din, din);
    check($sformatf("%s err", tag), 16'(err), 16'(e));
  endtask

  logic [15:0] bt_exp [4];

  initial begin
    p_reset = 1'b1;
    nop(16'h0, 1'b1);
    nop(16'h0, 1'b1);
    check_bus("reset", 1'b0, 16'h0000, 3'b000);
    p_reset = 1'b0;

    // CL=2 BL=4 write/read, CL=3 wrapped read, BL=1 byte masks.
    vecs.push_back(mk(CMD_MRS, 2'd0, 13'h022, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_WR,  2'd1, 13'h010, 2'b00, 16'h1111, 1'b0, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h2222, 1'b0, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h3333, 1'b0, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h4444, 1'b0, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h1111, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h2222, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h3333, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h4444, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_MRS, 2'd0, 13'h032, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_RD,  2'd1, 13'h012, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h3333, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h4444, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h1111, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h2222, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_MRS, 2'd0, 13'h020, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_WR,  2'd1, 13'h010, 2'b01, 16'hABCD, 1'b0, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'hAB11, 3'b000));
    vecs.push_back(mk(CMD_RD,  2'd1, 13'h010, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_RD,  2'd1, 13'h010, 2'b10, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b1, 16'h0011, 3'b000));
    vecs.push_back(mk(CMD_NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 1'b0, 16'h0000, 3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].dout, vecs[i].den);
      $display("vec %0d cmd=%b ba=%0d addr=%h doe=%b din=%h err=%b",
               i, vecs[i].cmd, vecs[i].ba, vecs[i].addr, SDRAM_Doe, SDRAM_Din, err);
      check_bus($sformatf("vec%0d", i), vecs[i].doe, vecs[i].din, vecs[i].err);
    end

    // BL=8 CL=2 read, BURST TERMINATE three edges later: four words then idle.
    bt_exp = '{16'hAB11, 16'h2222, 16'h3333, 16'h4444};
    drive(CMD_MRS, 2'd0, 13'h023, 2'b00, 16'h0, 1'b1);
    drive(CMD_RD, 2'd1, 13'h010, 2'b00, 16'h0, 1'b1);
    check_bus("bst rd", 1'b0, 16'h0000, 3'b000);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) drive(CMD_BST, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1);
      else nop(16'h0, 1'b1);
      $display("bst edge %0d doe=%b din=%h", i + 1, SDRAM_Doe, SDRAM_Din);
      check_bus($sformatf("bst%0d", i + 1), (i < 4), (i < 4) ? bt_exp[i] : 16'h0000, 3'b000);
    end

    // Idle-bank read, double ACTIVE, then reset clears the sticky flags.
    drive(CMD_RD, 2'd2, 13'h000, 2'b00, 16'h0, 1'b1);
    check_bus("idle rd", 1'b0, 16'h0000, 3'b001);
    nop(16'h0, 1'b1);
    check_bus("idle rd+1", 1'b0, 16'h0000, 3'b001);
    drive(CMD_ACT, 2'd0, 13'h003, 2'b00, 16'h0, 1'b1);
    check_bus("act1", 1'b0, 16'h0000, 3'b001);
    drive(CMD_ACT, 2'd0, 13'h003, 2'b00, 16'h0, 1'b1);
    check_bus("act2", 1'b0, 16'h0000, 3'b011);
    p_reset = 1'b1;
    nop(16'h0, 1'b1);
    check_bus("err reset", 1'b0, 16'h0000, 3'b000);
    p_reset = 1'b0;

    // Write with the controller not driving, then reset in the middle of a BL=8 read.
    drive(CMD_MRS, 2'd0, 13'h023, 2'b00, 16'h0, 1'b1);
    drive(CMD_ACT, 2'd1, 13'h005, 2'b00, 16'h0, 1'b1);
    drive(CMD_WR, 2'd1, 13'h010, 2'b00, 16'h5A5A, 1'b1);
    check_bus("den wr", 1'b0, 16'h0000, 3'b100);
    nop(16'h5A5A, 1'b1);
    nop(16'h5A5A, 1'b1);
    drive(CMD_RD, 2'd1, 13'h010, 2'b00, 16'h0, 1'b1);
    check_bus("mid rd", 1'b0, 16'h0000, 3'b100);
    nop(16'h0, 1'b1);
    check_bus("mid rd1", 1'b1, 16'h5A5A, 3'b100);
    nop(16'h0, 1'b1);
    check_bus("mid rd2", 1'b1, 16'h5A5A, 3'b100);
    p_reset = 1'b1;
    nop(16'h0, 1'b1);
    check_bus("mid reset", 1'b0, 16'h0000, 3'b000);
    nop(16'h0, 1'b1);
    p_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nop(16'h0, 1'b1);
      check_bus($sformatf("post reset%0d", i), 1'b0, 16'h0000, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
